// File: rtl/uart_io_nios2_qsys_cpu_debug_mem_ctrl.sv
// JTAG debug-memory access controller: turns debug-slave command strobes into
// single Avalon-style read/write accesses with stall timeout and overrun flags.
module uart_io_nios2_qsys_cpu_debug_mem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              mon_busy,
  output logic              mon_timeout,
  output logic              mon_overrun
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        mon_dreg_q, mon_dreg_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   stall_inc;
  logic               any_strobe;

  // Bits of the JTAG word that carry nothing for this block.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37], jdo[2:0]};

  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign stall_inc  = stall_cnt_q + CNT_W'(1);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mon_dreg_d  = mon_dreg_q;
    timeout_d   = timeout_q;
    overrun_d   = overrun_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          state_d = WRITE;
        end else if (take_action_ocimem_a) begin
          addr_d = jdo[ADDR_W+16:17];
          if (jdo[36]) begin
            timeout_d = 1'b0;
            overrun_d = 1'b0;
          end
          if (jdo[35]) state_d = READ;
        end else if (take_no_action_ocimem_a) begin
          state_d = READ;
        end
      end

      READ, WRITE: begin
        if (any_strobe) overrun_d = 1'b1;
        if (!mem_waitrequest) begin
          if (state_q == READ) mon_dreg_d = mem_rdata;
          addr_d      = addr_q + ADDR_W'(1);
          state_d     = IDLE;
          stall_cnt_d = '0;
        end else if (stall_inc >= CNT_W'(TIMEOUT)) begin
          // Abort: request drops, address and read data stay as they were.
          timeout_d   = 1'b1;
          state_d     = IDLE;
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = stall_inc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mon_dreg_q  <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mon_dreg_q  <= mon_dreg_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Requests decode straight from state, so an async reset drops them without a clock.
  assign mem_read    = (state_q == READ);
  assign mem_write   = (state_q == WRITE);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign MonDReg     = mon_dreg_q;
  assign mon_busy    = (state_q != IDLE);
  assign mon_timeout = timeout_q;
  assign mon_overrun = overrun_q;

endmodule

// File: doc/uart_io_nios2_qsys_cpu_debug_mem_ctrl.md
UART_IO_NIOS2_QSYS_CPU_DEBUG_MEM_CTRL -- requirements
Module: uart_io_nios2_qsys_cpu_debug_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: debug-memory word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum mem_waitrequest cycles tolerated per access.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous assertion, active-low.
REQ-005 SHALL have port jdo, input, 38: JTAG command/data word from the debug-slave sysclk stage.
REQ-006 SHALL have port take_action_ocimem_a, input, 1: one-cycle strobe, address-load command.
REQ-007 SHALL have port take_no_action_ocimem_a, input, 1: one-cycle strobe, read at current address.
REQ-008 SHALL have port take_action_ocimem_b, input, 1: one-cycle strobe, write at current address.
REQ-009 SHALL have ports mem_addr (output, ADDR_W), mem_wdata (output, 32), mem_read (output, 1) and mem_write (output, 1): Avalon-style master request.
REQ-010 SHALL have ports mem_rdata (input, 32) and mem_waitrequest (input, 1): read data and stall.
REQ-011 SHALL have port MonDReg, output, 32: last read data, returned to the debug slave.
REQ-012 SHALL have port mon_busy, output, 1: high while an access is outstanding.
REQ-013 SHALL have ports mon_timeout (output, 1) and mon_overrun (output, 1): sticky error flags.

Function
REQ-014 SHALL implement FSM states IDLE, READ and WRITE.
REQ-015 SHALL accept commands only in IDLE.
REQ-016 SHALL apply take_action_ocimem_a as follows: addr <= jdo[ADDR_W+16:17]; if jdo[36]=1, clear mon_timeout and mon_overrun; if jdo[35]=1, enter READ the next cycle.
REQ-017 SHALL enter READ at the current address on take_no_action_ocimem_a.
REQ-018 SHALL, on take_action_ocimem_b, latch mem_wdata <= jdo[34:3] and enter WRITE.
REQ-019 SHALL resolve strobes arriving in the same cycle by priority ocimem_b > ocimem_a > no_action_a; lower-priority strobes are dropped without raising an error.
REQ-020 SHALL, on any strobe arriving outside IDLE, ignore the strobe and set mon_overrun.
REQ-021 SHALL drive mem_read=1 throughout READ and mem_write=1 throughout WRITE, with mem_addr=addr; both SHALL be 0 in IDLE.
REQ-022 SHALL complete an access in the cycle the request is high and mem_waitrequest=0.
REQ-023 SHALL, on read completion, latch MonDReg <= mem_rdata (zero-latency read data).
REQ-024 SHALL, on any completion, increment addr modulo 2^ADDR_W (all-ones wraps to 0) and return to IDLE.
REQ-025 SHALL count consecutive stalled cycles per access, with the counter cleared on FSM entry.
REQ-026 SHALL abort an access once the stall count reaches TIMEOUT: drop the request, set mon_timeout, leave MonDReg and addr unchanged, and return to IDLE.
REQ-027 SHALL give minimum latency, strobe to completion, of 2 cycles: request asserted the cycle after the strobe, MonDReg valid the cycle after completion.
REQ-028 SHALL, when a read is launched via take_action_ocimem_a with jdo[35]=1, use the newly loaded address.
REQ-029 SHALL drive mon_busy = (state != IDLE), combinationally.

Reset
REQ-030 SHALL, on reset_n=0, immediately and asynchronously force state=IDLE, addr=0, MonDReg=0, mem_wdata=0, mem_read=0, mem_write=0, mon_timeout=0, mon_overrun=0 and stall count=0.
REQ-031 SHALL treat reset mid-access as an abort with no completion effects (no MonDReg update, no addr increment, no flag set).
REQ-032 SHALL synchronize deassertion of reset_n to clk externally; the first strobe is accepted one cycle after deassertion.

Verification
REQ-033 SHALL verify address load and read: ocimem_a with jdo[35]=1, address 0x10; memory returns 0xCAFEF00D with 0 wait -> mem_addr=0x10, MonDReg=0xCAFEF00D, addr=0x11.
REQ-034 SHALL verify write burst with wrap: addr set to 0xFF; two ocimem_b strobes with data 0x11111111 then 0x22222222 -> writes land at 0xFF then 0x00; addr ends at 0x01.
REQ-035 SHALL verify timeout: read with mem_waitrequest held high -> request drops after exactly 15 stall cycles; mon_timeout=1, MonDReg unchanged, addr unchanged.
REQ-036 SHALL verify overrun and clear: no_action_a issued while a read is stalled -> mon_overrun=1; a later ocimem_a with jdo[36]=1 -> both flags cleared.
REQ-037 SHALL verify simultaneous strobes: ocimem_b and no_action_a in the same cycle -> only the write executes; mon_overrun stays 0.
REQ-038 SHALL verify reset mid-read: reset_n pulsed low during a stalled read -> mem_read falls with no clock edge; all outputs return to 0.
